apb_protocol_checker: RTL
=========================

APB_PROTOCOL_CHECKER -- requirements
Module: apb_protocol_checker

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 8, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width; multiple of 8.
- NUM_SLV, 1, PSEL vector width.
- TIMEOUT, 16, wait-state limit; minimum 2.
REQ-002 Ports, one per line (name, direction, width, meaning):
- PCLK, in, 1, single clock.
- PRESET, in, 1, asynchronous active-high reset.
- PSEL, in, NUM_SLV, slave selects.
- PENABLE, in, 1, access phase.
- PWRITE, in, 1, direction.
- PADDR, in, ADDR_W, address.
- PWDATA, in, DATA_W, write data.
- PSTRB, in, DATA_W/8, byte strobes.
- PREADY, in, 1, slave ready.
- PSLVERR, in, 1, slave error.
- clr_in, in, 1, synchronous clear of sticky flags and counters.
- viol_sticky, out, 8, latched violation bits.
- viol_pulse, out, 1, one-cycle strobe on any new violation.
- xfer_cnt, out, 16, completed transfers.
- err_cnt, out, 16, completed transfers with PSLVERR.
- busy, out, 1, checker state is not IDLE.
REQ-003 The block is a passive monitor and SHALL drive no bus signal.

Function
REQ-004 Each sampled cycle SHALL be classified as IDLE-class (PSEL==0), SETUP-class (PSEL!=0, !PENABLE) or ACCESS-class (PSEL!=0, PENABLE).
REQ-005 FSM states SHALL be IDLE, SETUP and WAIT. Next state: SETUP-class -> SETUP; ACCESS-class with !PREADY -> WAIT; otherwise -> IDLE. Violations SHALL NOT alter this rule, so the FSM self-resyncs.
REQ-006 On every SETUP-class cycle the block SHALL capture PSEL, PADDR, PWRITE, PWDATA and PSTRB.
REQ-007 Violation bits:
- [0] SETUP_NO_ACCESS: state SETUP and sample is not ACCESS-class.
- [1] ACCESS_NO_SETUP: state IDLE and sample is ACCESS-class.
- [2] MULTI_SEL: more than one PSEL bit set, any state.
- [3] UNSTABLE: state SETUP/WAIT, sample ACCESS-class, and any captured field differs; PWDATA compared only when PWRITE=1.
- [4] TIMEOUT: wait counter reaches TIMEOUT.
- [5] STRB_ON_READ: PSTRB!=0 on a SETUP-class cycle with PWRITE=0.
- [6] ABORT: state WAIT and sample is not ACCESS-class.
- [7] Reserved, reads 0.
REQ-008 Violation detection SHALL be registered: viol_sticky bits set and viol_pulse asserts on the edge sampling the offense, visible one cycle later. viol_pulse is high exactly one cycle per offending sample.
REQ-009 Wait counter: increments on each ACCESS-class cycle with !PREADY and clears on any other cycle. Bit [4] SHALL set once when the count equals TIMEOUT. The counter then saturates, with no repeated pulse until it clears.
REQ-010 A transfer completes on an ACCESS-class cycle with PREADY=1. Completion SHALL increment xfer_cnt, and also err_cnt if PSLVERR=1. PSLVERR is ignored at all other times.
REQ-011 Counters SHALL saturate at 16'hFFFF.
REQ-012 clr_in SHALL zero viol_sticky, xfer_cnt and err_cnt on the next edge. A violation or completion on the same edge wins: that bit is set, or the counter loads 1.
REQ-013 busy = (state != IDLE).

Reset
REQ-014 PRESET SHALL asynchronously force state IDLE and zero viol_sticky, viol_pulse, xfer_cnt, err_cnt, the wait counter and the capture registers. busy is therefore 0.
REQ-015 A reset mid-transfer SHALL discard the transfer without counting or flagging it. The first post-reset ACCESS-class sample without a preceding SETUP SHALL flag bit [1].

Structure
REQ-016 Package apb_chk_pkg SHALL hold the state enum (IDLE, SETUP, WAIT) and the violation bit-index constants.
REQ-017 One sub-module, apb_sat_cnt (parametrised width, increment, synchronous clear, saturation), SHALL be instantiated for xfer_cnt and err_cnt.

Verification
REQ-018 Legal write, 2 wait states (SETUP, then ACCESS with PREADY=0,0,1), PADDR=8'h10 -> xfer_cnt=1, viol_sticky=0, busy back to 0.
REQ-019 PSEL=2'b11 with NUM_SLV=2 -> viol_sticky[2]=1 and viol_pulse high one cycle.
REQ-020 PADDR changes 8'h10->8'h14 between SETUP and ACCESS -> viol_sticky[3]=1; transfer still counted when PREADY=1.
REQ-021 PREADY held low for 20 cycles with TIMEOUT=16 -> exactly one viol_pulse, on the 16th wait cycle (+1 registered), and bit [4] set.
REQ-022 Read with PSLVERR=1 at completion, then clr_in coincident with a second completion -> err_cnt=1, then xfer_cnt=1 after clear.
REQ-023 PRESET asserted during WAIT, then ACCESS-class sample -> all outputs 0 during reset, then viol_sticky[1]=1.

Source files
------------

// File: rtl/apb_chk_pkg.sv
// Shared definitions for the APB protocol checker.
//   - apb_state_e : bus-phase tracking states (IDLE, SETUP, WAIT)
//   - V_*         : bit positions inside the violation vector
//   - multi_hot() : true when more than one bit of a select vector is set
package apb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } apb_state_e;

  localparam int unsigned NUM_VIOL          = 8;
  localparam int unsigned V_SETUP_NO_ACCESS = 0;
  localparam int unsigned V_ACCESS_NO_SETUP = 1;
  localparam int unsigned V_MULTI_SEL       = 2;
  localparam int unsigned V_UNSTABLE        = 3;
  localparam int unsigned V_TIMEOUT         = 4;
  localparam int unsigned V_STRB_ON_READ    = 5;
  localparam int unsigned V_ABORT           = 6;
  localparam int unsigned V_RESERVED        = 7;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [31:0] v);
    return ((v & (v - 32'd1)) != 32'd0);
  endfunction

endpackage

// File: rtl/apb_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear; an increment on the same edge loads 1
//   inc      : count enable
//   cnt      : current count, sticks at all-ones
module apb_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear wins over hold, but a coincident increment still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? ONE : {W{1'b0}};
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol monitor. Tracks bus phase, flags protocol violations
// (sticky vector plus a one-cycle strobe) and counts completed transfers.
//   PCLK, PRESET       : clock, asynchronous active-high reset
//   PSEL .. PSLVERR    : observed APB signals (inputs only, nothing driven)
//   clr_in             : synchronous clear of sticky flags and counters
//   viol_sticky[7:0]   : latched violations, bit 7 reserved (0)
//   viol_pulse         : high one cycle after each offending sample
//   xfer_cnt, err_cnt  : saturating completed / errored transfer counts
//   busy               : phase tracker is not IDLE
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [NUM_SLV-1:0]  PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic                PSLVERR,
  input  logic                clr_in,
  output logic [7:0]          viol_sticky,
  output logic                viol_pulse,
  output logic [15:0]         xfer_cnt,
  output logic [15:0]         err_cnt,
  output logic                busy
);

  localparam int                WC_W       = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0]   WC_ONE     = {{(WC_W-1){1'b0}}, 1'b1};
  localparam logic [WC_W-1:0]   WC_LIMIT   = WC_W'(TIMEOUT);
  localparam logic [WC_W-1:0]   WC_PRE_LIM = WC_W'(TIMEOUT - 1);

  // Sample classification.
  logic sel_any;
  logic setup_cls;
  logic access_cls;
  logic complete;

  assign sel_any    = (PSEL != {NUM_SLV{1'b0}});
  assign setup_cls  = sel_any & ~PENABLE;
  assign access_cls = sel_any & PENABLE;
  assign complete   = access_cls & PREADY;

  apb_state_e state_d, state_q;

  logic [NUM_SLV-1:0]  cap_psel_d,   cap_psel_q;
  logic [ADDR_W-1:0]   cap_paddr_d,  cap_paddr_q;
  logic                cap_pwrite_d, cap_pwrite_q;
  logic [DATA_W-1:0]   cap_pwdata_d, cap_pwdata_q;
  logic [DATA_W/8-1:0] cap_pstrb_d,  cap_pstrb_q;
  logic [WC_W-1:0]     wait_cnt_d,   wait_cnt_q;
  logic [7:0]          sticky_d,     sticky_q;
  logic                pulse_d,      pulse_q;
  logic                busy_d,       busy_q;

  logic       in_idle;
  logic       in_setup;
  logic       in_wait;
  logic       fields_differ;
  logic [7:0] viol_now;

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state depends only on the sample class, so violations never lock it up.
  always_comb begin
    state_d = IDLE;
    if (setup_cls) begin
      state_d = SETUP;
    end else if (access_cls && !PREADY) begin
      state_d = WAIT;
    end else begin
      state_d = IDLE;
    end
  end

  // Violation decode from current state and sample.
  always_comb begin
    in_idle  = 1'b0;
    in_setup = 1'b0;
    in_wait  = 1'b0;
    case (state_q)
      IDLE:    in_idle  = 1'b1;
      SETUP:   in_setup = 1'b1;
      WAIT:    in_wait  = 1'b1;
      default: in_idle  = 1'b1;
    endcase

    // Write data only matters when the captured access is a write.
    fields_differ = (PSEL   != cap_psel_q)   |
                    (PADDR  != cap_paddr_q)  |
                    (PWRITE != cap_pwrite_q) |
                    (PSTRB  != cap_pstrb_q)  |
                    (cap_pwrite_q & (PWDATA != cap_pwdata_q));

    viol_now                    = 8'h00;
    viol_now[V_SETUP_NO_ACCESS] = in_setup & ~access_cls;
    viol_now[V_ACCESS_NO_SETUP] = in_idle & access_cls;
    viol_now[V_MULTI_SEL]       = multi_hot(32'(PSEL));
    viol_now[V_UNSTABLE]        = (in_setup | in_wait) & access_cls & fields_differ;
    // Fires on the sample that brings the count to TIMEOUT; saturation stops repeats.
    viol_now[V_TIMEOUT]         = access_cls & ~PREADY & (wait_cnt_q == WC_PRE_LIM);
    viol_now[V_STRB_ON_READ]    = setup_cls & ~PWRITE & (PSTRB != {(DATA_W/8){1'b0}});
    viol_now[V_ABORT]           = in_wait & ~access_cls;
    viol_now[V_RESERVED]        = 1'b0;
  end

  // Next values for capture, wait counter and flag registers.
  always_comb begin
    cap_psel_d   = cap_psel_q;
    cap_paddr_d  = cap_paddr_q;
    cap_pwrite_d = cap_pwrite_q;
    cap_pwdata_d = cap_pwdata_q;
    cap_pstrb_d  = cap_pstrb_q;
    if (setup_cls) begin
      cap_psel_d   = PSEL;
      cap_paddr_d  = PADDR;
      cap_pwrite_d = PWRITE;
      cap_pwdata_d = PWDATA;
      cap_pstrb_d  = PSTRB;
    end else begin
      cap_psel_d   = cap_psel_q;
      cap_paddr_d  = cap_paddr_q;
      cap_pwrite_d = cap_pwrite_q;
      cap_pwdata_d = cap_pwdata_q;
      cap_pstrb_d  = cap_pstrb_q;
    end

    if (access_cls && !PREADY) begin
      wait_cnt_d = (wait_cnt_q == WC_LIMIT) ? wait_cnt_q : (wait_cnt_q + WC_ONE);
    end else begin
      wait_cnt_d = {WC_W{1'b0}};
    end

    // A violation on the clearing edge survives the clear.
    if (clr_in) begin
      sticky_d = viol_now;
    end else begin
      sticky_d = sticky_q | viol_now;
    end
    pulse_d = (viol_now != 8'h00);
    busy_d  = (state_d != IDLE);
  end

  // Capture, wait counter and output flag registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cap_psel_q   <= {NUM_SLV{1'b0}};
      cap_paddr_q  <= {ADDR_W{1'b0}};
      cap_pwrite_q <= 1'b0;
      cap_pwdata_q <= {DATA_W{1'b0}};
      cap_pstrb_q  <= {(DATA_W/8){1'b0}};
      wait_cnt_q   <= {WC_W{1'b0}};
      sticky_q     <= 8'h00;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cap_psel_q   <= cap_psel_d;
      cap_paddr_q  <= cap_paddr_d;
      cap_pwrite_q <= cap_pwrite_d;
      cap_pwdata_q <= cap_pwdata_d;
      cap_pstrb_q  <= cap_pstrb_d;
      wait_cnt_q   <= wait_cnt_d;
      sticky_q     <= sticky_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
    end
  end

  apb_sat_cnt #(.W(16)) u_xfer_cnt (
    .clk (PCLK),
    .rst (PRESET),
    .clr (clr_in),
    .inc (complete),
    .cnt (xfer_cnt)
  );

  apb_sat_cnt #(.W(16)) u_err_cnt (
    .clk (PCLK),
    .rst (PRESET),
    .clr (clr_in),
    .inc (complete & PSLVERR),
    .cnt (err_cnt)
  );

  assign viol_sticky = sticky_q;
  assign viol_pulse  = pulse_q;
  assign busy        = busy_q;

endmodule
